mem_subword_rmw: RTL and testbench
==================================

Name: mem_subword_rmw

Overview:
- Sequential memory-access engine between the datapath and a word-addressed, single-port data memory.
- Handles full-word, halfword and byte loads and stores.
- Sub-word stores are done as read-modify-write, so neighbouring bytes in the word are kept.
- Sub-word loads return the extracted lane, zero- or sign-extended to full width.
- Generalises the existing fixed 32-bit word/half/byte zero-extend write-data select:
  - width is parametrised;
  - adds signed extension, byte-lane offsets and alignment checking;
  - adds a request/response handshake.

Parameters:
- DATA_W, 32: memory word width in bits. Power of two, ≥32.
- ADDR_W, 32: byte-address width.
- MEM_LAT, 1: memory read latency in cycles, ≥1. mem_rdata is valid MEM_LAT cycles after the cycle in which mem_rd is high.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- req_valid  in  1  request present.
- req_ready  out  1  engine idle; a request is accepted when req_valid && req_ready.
- req_write  in  1  1 = store, 0 = load.
- req_size  in  2  00 word, 01 half, 10 byte, 11 reserved.
- req_signed  in  1  loads only: 1 = sign-extend, 0 = zero-extend.
- req_addr  in  ADDR_W  byte address.
- req_wdata  in  DATA_W  store data; sub-word data sits in the low bits.
- resp_valid  out  1  one-cycle pulse: operation complete.
- resp_rdata  out  DATA_W  extended load data; 0 for stores and errors.
- resp_misaligned  out  1  valid with resp_valid; 1 = request rejected.
- mem_addr  out  ADDR_W  word-aligned address (low OFF_W bits forced to 0).
- mem_rd  out  1  memory read strobe.
- mem_wr  out  1  memory write strobe.
- mem_wdata  out  DATA_W  merged write word.
- mem_rdata  in  DATA_W  memory read data.

Behaviour:
- Offset: OFF_W = log2(DATA_W/8); off = req_addr[OFF_W-1:0].
- Byte lanes are little-endian: lane k = bits [8k+7:8k].
- FSM states: IDLE, READ, WAIT, WRITE, RESP.
  - req_ready = (state == IDLE).
  - All request fields are latched on accept.
- Misaligned conditions:
  - word with off ≠ 0;
  - half with off[0] = 1;
  - size 11.
- Transitions out of IDLE on accept:
  - Misaligned → RESP with resp_misaligned = 1. No mem_rd/mem_wr pulse ever.
  - Word store → WRITE.
  - Any load, or a half/byte store → READ.
- READ:
  - mem_rd = 1 for exactly one cycle; mem_addr held.
  - Next state is WAIT.
- WAIT:
  - Lasts MEM_LAT cycles (down-counter loaded with MEM_LAT-1).
  - mem_rdata is captured on the final WAIT cycle.
  - Then: load → RESP; sub-word store → WRITE.
- WRITE:
  - mem_wr = 1 for one cycle.
  - Word store: mem_wdata = req_wdata.
  - Sub-word store: mem_wdata = captured word with byte lane off (or lanes off, off+1 for half) replaced by req_wdata[7:0] (or [15:0]).
  - Next state is RESP.
- RESP:
  - resp_valid = 1 for one cycle; next state IDLE. No back-to-back accept in RESP.
  - Load data: the lane is extracted, then extended to DATA_W per req_signed. Word loads are returned unchanged.
- Latency, counted in cycles after the accept cycle, where resp_valid is high:
  - misaligned: 1;
  - word store: 2 (mem_wr in cycle 1);
  - load: 2+MEM_LAT;
  - sub-word store: 3+MEM_LAT.
- Outputs outside their active state:
  - mem_rd, mem_wr, resp_valid and resp_misaligned are 0.
  - resp_rdata is held at its last value, except it is cleared to 0 on any store/error response.
  - mem_addr and mem_wdata hold their last value.
- Reset (asynchronous, reset = 0):
  - state = IDLE; all registered outputs = 0; counter = 0.
  - req_ready = 1 while in reset.
  - Reset mid-operation aborts immediately. A pending mem_wr is dropped and no response is produced.
- req_valid while busy is ignored. The upstream holds it until req_ready.
- mem_rdata is ignored outside the capture cycle.

Test Plan:
- Memory word 0x100 = 0x11223344. sb addr 0x102, wdata 0x000000AB:
  - mem_rd then mem_wr at mem_addr 0x100 with mem_wdata 0x11AB3344;
  - resp_valid in cycle 3+MEM_LAT, resp_misaligned = 0.
- Same word, lb signed at 0x103 → resp_rdata 0x00000011. lh signed at 0x100 with word 0x8000FFFF → 0xFFFFFFFF; lhu → 0x0000FFFF. lbu at 0x101 of 0x11223380 → 0x00000033.
- sw 0x104, 0xDEADBEEF → no mem_rd; mem_wr cycle 1 with 0xDEADBEEF; resp_valid cycle 2. Then lw 0x104 returns 0xDEADBEEF.
- Error cases, each → resp_valid at cycle 1 with resp_misaligned = 1 and zero mem_rd/mem_wr pulses:
  - lh at 0x101;
  - sw at 0x102;
  - req_size = 11.
- MEM_LAT = 3 build: lb at 0x100 → resp_valid exactly at cycle 5. req_valid held high during the op is not accepted until req_ready returns.
- Sub-word store, reset pulled low during WAIT → outputs 0 asynchronously, no mem_wr ever, req_ready = 1. The next request completes normally.

Source files
------------

// File: rtl/mem_subword_rmw.sv
// Load/store engine for a word-addressed single-port memory. Sub-word stores
// are done as read-modify-write; sub-word loads are lane-extracted and extended.
module mem_subword_rmw #(
  parameter int DATA_W  = 32,
  parameter int ADDR_W  = 32,
  parameter int MEM_LAT = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [1:0]        req_size,
  input  logic              req_signed,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              resp_valid,
  output logic [DATA_W-1:0] resp_rdata,
  output logic              resp_misaligned,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_rd,
  output logic              mem_wr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);
  localparam int NUM_LANES = DATA_W / 8;
  localparam int OFF_W     = $clog2(NUM_LANES);
  localparam int CNT_W     = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;

  localparam logic [1:0] SZ_WORD = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_BYTE = 2'b10;
  localparam logic [1:0] SZ_RSVD = 2'b11;

  typedef enum logic [2:0] {S_IDLE, S_READ, S_WAIT, S_WRITE, S_RESP} state_t;

  state_t                         state_q, state_d;
  logic [CNT_W-1:0]               cnt_q;
  logic                           write_q, signed_q, mis_q;
  logic [1:0]                     size_q;
  logic [OFF_W-1:0]               off_q;
  logic [15:0]                    wlo_q;

  logic                           accept, req_mis, last_wait;
  logic [OFF_W-1:0]               req_off;
  logic [DATA_W-1:0]              shifted, load_ext;
  logic [NUM_LANES-1:0][7:0]      merged;

  assign req_off   = req_addr[OFF_W-1:0];
  assign req_mis   = (req_size == SZ_RSVD) ||
                     (req_size == SZ_WORD && req_off != '0) ||
                     (req_size == SZ_HALF && req_off[0]);
  assign accept    = req_valid && (state_q == S_IDLE);
  assign last_wait = (state_q == S_WAIT) && (cnt_q == '0);

  assign req_ready       = (state_q == S_IDLE);
  assign mem_rd          = (state_q == S_READ);
  assign mem_wr          = (state_q == S_WRITE);
  assign resp_valid      = (state_q == S_RESP);
  assign resp_misaligned = (state_q == S_RESP) && mis_q;

  // Load path: bring the addressed lane down to bit 0, then extend.
  assign shifted = mem_rdata >> {off_q, 3'b000};

  always_comb begin
    load_ext = shifted;
    case (size_q)
      SZ_HALF: load_ext = {{(DATA_W-16){signed_q & shifted[15]}}, shifted[15:0]};
      SZ_BYTE: load_ext = {{(DATA_W-8){signed_q & shifted[7]}}, shifted[7:0]};
      default: load_ext = shifted;
    endcase
  end

  // Store merge: each byte lane keeps the memory byte unless the store hits it.
  for (genvar k = 0; k < NUM_LANES; k++) begin : g_lane
    logic byte_hit, half_hit;
    assign byte_hit  = (size_q == SZ_BYTE) && (off_q == OFF_W'(k));
    assign half_hit  = (size_q == SZ_HALF) && (off_q == OFF_W'(k - (k % 2)));
    assign merged[k] = byte_hit ? wlo_q[7:0] :
                       half_hit ? wlo_q[8*(k%2) +: 8] :
                                  mem_rdata[8*k +: 8];
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (accept) begin
          if (req_mis)                              state_d = S_RESP;
          else if (req_write && req_size == SZ_WORD) state_d = S_WRITE;
          else                                      state_d = S_READ;
        end
      end
      S_READ:  state_d = S_WAIT;
      S_WAIT:  if (cnt_q == '0) state_d = write_q ? S_WRITE : S_RESP;
      S_WRITE: state_d = S_RESP;
      S_RESP:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      write_q    <= 1'b0;
      signed_q   <= 1'b0;
      mis_q      <= 1'b0;
      size_q     <= 2'b00;
      off_q      <= '0;
      wlo_q      <= '0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
      resp_rdata <= '0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        write_q  <= req_write;
        signed_q <= req_signed;
        mis_q    <= req_mis;
        size_q   <= req_size;
        off_q    <= req_off;
        wlo_q    <= req_wdata[15:0];
        // A rejected request never touches the memory interface.
        if (!req_mis) mem_addr <= {req_addr[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};
        if (!req_mis && req_write && req_size == SZ_WORD) mem_wdata <= req_wdata;
      end
      if (state_q == S_READ)
        cnt_q <= CNT_W'(MEM_LAT - 1);
      else if (state_q == S_WAIT && cnt_q != '0)
        cnt_q <= cnt_q - CNT_W'(1);
      if (last_wait) begin
        if (write_q) mem_wdata  <= merged;
        else         resp_rdata <= load_ext;
      end
      if ((accept && req_mis) || state_q == S_WRITE) resp_rdata <= '0;
    end
  end
endmodule

// File: tb/tb_mem_subword_rmw.sv
// Scoreboard bench for mem_subword_rmw against a small latency-accurate memory model.
module tb_mem_subword_rmw;
  localparam int LAT = 3;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid, req_ready, req_write, req_signed;
  logic [1:0]  req_size;
  logic [31:0] req_addr, req_wdata;
  logic        resp_valid, resp_misaligned;
  logic [31:0] resp_rdata;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic        mem_rd, mem_wr;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  mem_subword_rmw #(.DATA_W(32), .ADDR_W(32), .MEM_LAT(LAT)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_size(req_size), .req_signed(req_signed), .req_addr(req_addr),
    .req_wdata(req_wdata), .resp_valid(resp_valid), .resp_rdata(resp_rdata),
    .resp_misaligned(resp_misaligned), .mem_addr(mem_addr), .mem_rd(mem_rd),
    .mem_wr(mem_wr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  // Memory: read data appears LAT cycles after the mem_rd cycle, garbage otherwise.
  logic [31:0] mem   [0:255];
  logic [31:0] rpipe [LAT];
  logic        vpipe [LAT];
  int          wr_total = 0;
  int          acc_total = 0;

  always @(posedge clk) begin
    if (mem_wr) mem[mem_addr[9:2]] <= mem_wdata;
    vpipe[0] <= mem_rd;
    rpipe[0] <= mem[mem_addr[9:2]];
    for (int i = 1; i < LAT; i++) begin
      vpipe[i] <= vpipe[i-1];
      rpipe[i] <= rpipe[i-1];
    end
    wr_total  <= wr_total + int'(mem_wr);
    acc_total <= acc_total + int'(req_valid && req_ready);
  end
  assign mem_rdata = (vpipe[LAT-1] === 1'b1) ? rpipe[LAT-1] : 32'hBAD0_BAD0;

  typedef struct { logic [31:0] rdata; logic mis; } exp_t;
  exp_t sbq[$];
  exp_t mon_e;

  always @(negedge clk) begin
    if (resp_valid === 1'b1) begin
      checks++;
      if (sbq.size() == 0) begin
        failures++;
        $display("FAIL unexpected_resp rdata=%h mis=%b", resp_rdata, resp_misaligned);
      end else begin
        mon_e = sbq.pop_front();
        if (resp_rdata !== mon_e.rdata || resp_misaligned !== mon_e.mis) begin
          failures++;
          $display("FAIL resp_data got=%h/%b exp=%h/%b", resp_rdata, resp_misaligned,
                   mon_e.rdata, mon_e.mis);
        end
      end
    end
  end

  int          lat, nrd, nwr, rd_cyc, wr_cyc;
  logic [31:0] rd_addr, wr_addr, wr_data;

  task automatic issue(input logic w, input logic [1:0] sz, input logic sg,
                       input logic [31:0] a, input logic [31:0] d,
                       input bit push, input logic [31:0] er, input logic em);
    @(negedge clk);
    if (push) sbq.push_back('{er, em});
    req_write = w; req_size = sz; req_signed = sg; req_addr = a; req_wdata = d;
    req_valid = 1'b1;
    @(posedge clk);
    #1 req_valid = 1'b0;
  endtask

  // Cycle 1 is the cycle right after the accept edge; lat = -1 on timeout.
  task automatic wait_resp();
    lat = -1; nrd = 0; nwr = 0; rd_cyc = -1; wr_cyc = -1;
    for (int c = 1; c <= 30; c++) begin
      @(negedge clk);
      if (mem_rd === 1'b1) begin nrd++; if (rd_cyc < 0) rd_cyc = c; rd_addr = mem_addr; end
      if (mem_wr === 1'b1) begin nwr++; wr_cyc = c; wr_addr = mem_addr; wr_data = mem_wdata; end
      if (resp_valid === 1'b1) begin lat = c; break; end
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; req_valid = 1'b0; req_write = 1'b0; req_size = 2'b00;
    req_signed = 1'b0; req_addr = '0; req_wdata = '0;
    #3 reset = 1'b0;
    #1;
    checks++;
    if (req_ready !== 1'b1 || mem_rd !== 1'b0 || mem_wr !== 1'b0 ||
        resp_valid !== 1'b0 || resp_misaligned !== 1'b0) begin
      failures++;
      $display("FAIL reset_ctrl ready=%b rd=%b wr=%b rv=%b mis=%b exp 1/0/0/0/0",
               req_ready, mem_rd, mem_wr, resp_valid, resp_misaligned);
    end
    checks++;
    if (resp_rdata !== 32'h0 || mem_addr !== 32'h0 || mem_wdata !== 32'h0) begin
      failures++;
      $display("FAIL reset_data rdata=%h addr=%h wdata=%h exp 0", resp_rdata, mem_addr, mem_wdata);
    end
    repeat (2) @(negedge clk);
    reset = 1'b1;
  endtask

  task automatic test_word_store();
    issue(1'b1, 2'b00, 1'b0, 32'h100, 32'h1122_3344, 1'b1, 32'h0, 1'b0);
    wait_resp();
    checks++;
    if (lat !== 2 || nrd !== 0 || nwr !== 1 || wr_cyc !== 1) begin
      failures++;
      $display("FAIL sw_timing lat=%0d nrd=%0d nwr=%0d wr_cyc=%0d exp 2/0/1/1", lat, nrd, nwr, wr_cyc);
    end
    checks++;
    if (wr_addr !== 32'h100 || wr_data !== 32'h1122_3344) begin
      failures++;
      $display("FAIL sw_data addr=%h data=%h exp 100/11223344", wr_addr, wr_data);
    end
    issue(1'b1, 2'b00, 1'b0, 32'h104, 32'hDEAD_BEEF, 1'b1, 32'h0, 1'b0);
    wait_resp();
    checks++;
    if (lat !== 2 || nrd !== 0 || wr_cyc !== 1 || wr_addr !== 32'h104 || wr_data !== 32'hDEAD_BEEF) begin
      failures++;
      $display("FAIL sw2 lat=%0d nrd=%0d wr_cyc=%0d addr=%h data=%h exp 2/0/1/104/deadbeef",
               lat, nrd, wr_cyc, wr_addr, wr_data);
    end
    issue(1'b0, 2'b00, 1'b0, 32'h104, 32'h0, 1'b1, 32'hDEAD_BEEF, 1'b0);
    wait_resp();
    checks++;
    if (lat !== 2 + LAT || nrd !== 1 || nwr !== 0 || rd_addr !== 32'h104) begin
      failures++;
      $display("FAIL lw_timing lat=%0d nrd=%0d nwr=%0d addr=%h exp %0d/1/0/104",
               lat, nrd, nwr, rd_addr, 2 + LAT);
    end
    @(negedge clk);
    checks++;
    if (resp_rdata !== 32'hDEAD_BEEF) begin
      failures++;
      $display("FAIL rdata_hold got=%h exp=deadbeef", resp_rdata);
    end
  endtask

  task automatic test_subword_store();
    issue(1'b1, 2'b10, 1'b0, 32'h102, 32'h0000_00AB, 1'b1, 32'h0, 1'b0);
    wait_resp();
    checks++;
    if (lat !== 3 + LAT || nrd !== 1 || rd_cyc !== 1 || nwr !== 1 || wr_cyc !== 2 + LAT) begin
      failures++;
      $display("FAIL sb_timing lat=%0d nrd=%0d rd_cyc=%0d nwr=%0d wr_cyc=%0d exp %0d/1/1/1/%0d",
               lat, nrd, rd_cyc, nwr, wr_cyc, 3 + LAT, 2 + LAT);
    end
    checks++;
    if (rd_addr !== 32'h100 || wr_addr !== 32'h100 || wr_data !== 32'h11AB_3344) begin
      failures++;
      $display("FAIL sb_data raddr=%h waddr=%h data=%h exp 100/100/11ab3344", rd_addr, wr_addr, wr_data);
    end
    issue(1'b1, 2'b01, 1'b0, 32'h106, 32'h0000_CAFE, 1'b1, 32'h0, 1'b0);
    wait_resp();
    checks++;
    if (lat !== 3 + LAT || wr_addr !== 32'h104 || wr_data !== 32'hCAFE_BEEF) begin
      failures++;
      $display("FAIL sh_data lat=%0d addr=%h data=%h exp %0d/104/cafebeef", lat, wr_addr, wr_data, 3 + LAT);
    end
  endtask

  task automatic test_loads();
    logic [31:0] wd [8] = '{32'h8000_FFFF, 32'h8000_FFFF, 32'h8000_FFFF, 32'h8000_FFFF,
                            32'h1122_3380, 32'h1122_3380, 32'h1122_3380, 32'h1122_3380};
    logic [1:0]  sz [8] = '{2'b01, 2'b01, 2'b01, 2'b01, 2'b10, 2'b10, 2'b10, 2'b00};
    logic        sg [8] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
    logic [31:0] ad [8] = '{32'h100, 32'h100, 32'h102, 32'h102, 32'h101, 32'h100, 32'h100, 32'h100};
    logic [31:0] ex [8] = '{32'hFFFF_FFFF, 32'h0000_FFFF, 32'hFFFF_8000, 32'h0000_8000,
                            32'h0000_0033, 32'hFFFF_FF80, 32'h0000_0080, 32'h1122_3380};
    // Word left behind by the byte store.
    issue(1'b0, 2'b10, 1'b1, 32'h103, 32'h0, 1'b1, 32'h0000_0011, 1'b0);
    wait_resp();
    for (int i = 0; i < 8; i++) begin
      issue(1'b1, 2'b00, 1'b0, 32'h100, wd[i], 1'b1, 32'h0, 1'b0);
      wait_resp();
      issue(1'b0, sz[i], sg[i], ad[i], 32'hFFFF_FFFF, 1'b1, ex[i], 1'b0);
      wait_resp();
      checks++;
      if (lat !== 2 + LAT || nrd !== 1 || nwr !== 0) begin
        failures++;
        $display("FAIL load_timing[%0d] lat=%0d nrd=%0d nwr=%0d exp %0d/1/0", i, lat, nrd, nwr, 2 + LAT);
      end
    end
  endtask

  task automatic test_misaligned();
    logic        w  [5] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
    logic [1:0]  sz [5] = '{2'b01, 2'b00, 2'b11, 2'b11, 2'b00};
    logic [31:0] ad [5] = '{32'h101, 32'h102, 32'h100, 32'h100, 32'h103};
    issue(1'b0, 2'b00, 1'b0, 32'h104, 32'h0, 1'b1, 32'hCAFE_BEEF, 1'b0);
    wait_resp();
    for (int i = 0; i < 5; i++) begin
      issue(w[i], sz[i], 1'b1, ad[i], 32'hFFFF_FFFF, 1'b1, 32'h0, 1'b1);
      wait_resp();
      checks++;
      if (lat !== 1 || nrd !== 0 || nwr !== 0) begin
        failures++;
        $display("FAIL misaligned[%0d] lat=%0d nrd=%0d nwr=%0d exp 1/0/0", i, lat, nrd, nwr);
      end
    end
    issue(1'b0, 2'b00, 1'b0, 32'h100, 32'h0, 1'b1, 32'h1122_3380, 1'b0);
    wait_resp();
  endtask

  task automatic test_back_to_back();
    int a0, r1, r2, busy_ready;
    @(negedge clk);
    a0 = acc_total;
    sbq.push_back('{32'hFFFF_FF80, 1'b0});
    req_write = 1'b0; req_size = 2'b10; req_signed = 1'b1; req_addr = 32'h100; req_valid = 1'b1;
    r1 = -1; r2 = -1; busy_ready = 0;
    for (int c = 1; c <= 30; c++) begin
      @(negedge clk);
      if (c == 1) begin
        sbq.push_back('{32'h0000_0033, 1'b0});
        req_signed = 1'b0; req_addr = 32'h101;
      end
      if (r1 < 0 && req_ready !== 1'b0) busy_ready++;
      if (acc_total - a0 >= 2) req_valid = 1'b0;
      if (resp_valid === 1'b1) begin
        if (r1 < 0) begin
          r1 = c;
          checks++;
          if (acc_total - a0 !== 1) begin
            failures++;
            $display("FAIL b2b_busy_accept accepts=%0d exp 1", acc_total - a0);
          end
        end else begin
          r2 = c;
          break;
        end
      end
    end
    req_valid = 1'b0;
    checks++;
    if (r1 !== 2 + LAT || r2 !== 2 * (2 + LAT) + 1 || busy_ready !== 0) begin
      failures++;
      $display("FAIL b2b_timing r1=%0d r2=%0d busy_ready=%0d exp %0d/%0d/0",
               r1, r2, busy_ready, 2 + LAT, 2 * (2 + LAT) + 1);
    end
  endtask

  task automatic test_reset_mid_op();
    int wr0;
    issue(1'b1, 2'b10, 1'b0, 32'h101, 32'h0000_0055, 1'b0, 32'h0, 1'b0);
    repeat (3) @(negedge clk);
    wr0 = wr_total;
    #1 reset = 1'b0;
    #1;
    checks++;
    if (req_ready !== 1'b1 || mem_rd !== 1'b0 || mem_wr !== 1'b0 || resp_valid !== 1'b0 ||
        mem_addr !== 32'h0 || mem_wdata !== 32'h0 || resp_rdata !== 32'h0) begin
      failures++;
      $display("FAIL midop_reset ready=%b rd=%b wr=%b rv=%b addr=%h wdata=%h rdata=%h exp 1/0/0/0/0/0/0",
               req_ready, mem_rd, mem_wr, resp_valid, mem_addr, mem_wdata, resp_rdata);
    end
    repeat (3) @(negedge clk);
    reset = 1'b1;
    repeat (3) @(negedge clk);
    checks++;
    if (wr_total !== wr0) begin
      failures++;
      $display("FAIL midop_no_write writes=%0d exp 0", wr_total - wr0);
    end
    issue(1'b0, 2'b00, 1'b0, 32'h100, 32'h0, 1'b1, 32'h1122_3380, 1'b0);
    wait_resp();
    issue(1'b1, 2'b10, 1'b0, 32'h101, 32'h0000_0055, 1'b1, 32'h0, 1'b0);
    wait_resp();
    checks++;
    if (lat !== 3 + LAT || wr_data !== 32'h1122_5580) begin
      failures++;
      $display("FAIL post_reset_sb lat=%0d data=%h exp %0d/11225580", lat, wr_data, 3 + LAT);
    end
    issue(1'b0, 2'b00, 1'b0, 32'h100, 32'h0, 1'b1, 32'h1122_5580, 1'b0);
    wait_resp();
  endtask

  initial begin
    test_reset();
    test_word_store();
    test_subword_store();
    test_loads();
    test_misaligned();
    test_back_to_back();
    test_reset_mid_op();
    repeat (3) @(negedge clk);
    checks++;
    if (sbq.size() != 0) begin
      failures++;
      $display("FAIL missing_resp pending=%0d exp 0", sbq.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
